// File: rtl/decode_ctrl_seq.sv
// Registered decode-stage control sequencer: IF/ID opcode -> ID/EX control word with
// valid/ready, stall hold, flush kill, MUL throttling and TLBWRITE/IRET drain.
// Optional illegal-opcode pulse: define DECODE_ILLEGAL_TRAP_EN.
module decode_ctrl_seq #(
    parameter int OPC_W   = 6,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [OPC_W-1:0] opcode,
    input  logic             stall_in,
    input  logic             flush,
    input  logic             ex_empty,
    output logic             ready,
    output logic             ctrl_valid,
    output logic             reg_dst,
    output logic             branch,
    output logic             mem_read,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic             alu_src,
    output logic             reg_write,
    output logic             jump,
    output logic             word,
    output logic             tlb_write,
    output logic             iret,
    output logic             ignore_op2,
    output logic             busy
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic             illegal_op
`endif
);

    localparam logic [OPC_W-1:0] OP_ADD    = OPC_W'(8'h00);
    localparam logic [OPC_W-1:0] OP_SUB    = OPC_W'(8'h01);
    localparam logic [OPC_W-1:0] OP_MUL    = OPC_W'(8'h02);
    localparam logic [OPC_W-1:0] OP_LDB    = OPC_W'(8'h10);
    localparam logic [OPC_W-1:0] OP_LDW    = OPC_W'(8'h11);
    localparam logic [OPC_W-1:0] OP_STB    = OPC_W'(8'h12);
    localparam logic [OPC_W-1:0] OP_STW    = OPC_W'(8'h13);
    localparam logic [OPC_W-1:0] OP_MOVRM1 = OPC_W'(8'h20);
    localparam logic [OPC_W-1:0] OP_BEQ    = OPC_W'(8'h30);
    localparam logic [OPC_W-1:0] OP_JUMP   = OPC_W'(8'h31);
    localparam logic [OPC_W-1:0] OP_TLBWR  = OPC_W'(8'h3C);
    localparam logic [OPC_W-1:0] OP_IRET   = OPC_W'(8'h3D);

    localparam logic [CNT_W-1:0] MUL_WAIT_CNT = CNT_W'(MUL_LAT - 1);

    typedef struct packed {
        logic reg_dst;
        logic branch;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic reg_write;
        logic jump;
        logic word;
        logic tlb_write;
        logic iret;
        logic ignore_op2;
    } ctrl_t;

    typedef enum logic [1:0] {RUN, MUL_WAIT, DRAIN, ISSUED} state_t;

    function automatic ctrl_t decode(input logic [OPC_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_LDB, OP_LDW: begin
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
                c.reg_write  = 1'b1;
                c.word       = (op == OP_LDW);
            end
            OP_STB, OP_STW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.word      = (op == OP_STW);
            end
            OP_BEQ:  c.branch = 1'b1;
            OP_JUMP: c.jump   = 1'b1;
            OP_MOVRM1: begin
                c.reg_dst    = 1'b1;
                c.reg_write  = 1'b1;
                c.ignore_op2 = 1'b1;
            end
            OP_TLBWR: c.tlb_write = 1'b1;
            OP_IRET:  c.iret      = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_iret_q, pend_iret_d;
    logic             xfer, is_serial;

    assign ready     = (state_q == RUN) && !stall_in && !reset;
    assign xfer      = instr_valid && ready;
    assign is_serial = (opcode == OP_TLBWR) || (opcode == OP_IRET);
    assign busy      = (state_q != RUN);

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic ill_q, ill_d;
    logic op_defined;
    always_comb begin
        op_defined = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_STB, OP_STW,
            OP_MOVRM1, OP_BEQ, OP_JUMP, OP_TLBWR, OP_IRET: op_defined = 1'b1;
            default: op_defined = 1'b0;
        endcase
    end
    assign illegal_op = ill_q;
`endif

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        vld_d       = vld_q;
        cnt_d       = cnt_q;
        pend_iret_d = pend_iret_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
        ill_d       = ill_q;
`endif
        if (flush) begin
            state_d = RUN;
            ctrl_d  = '0;
            vld_d   = 1'b0;
            cnt_d   = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ill_d   = 1'b0;
`endif
        end else if (!stall_in) begin
            // anything not explicitly issued below becomes a clean bubble
            ctrl_d = '0;
            vld_d  = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ill_d  = 1'b0;
`endif
            case (state_q)
                RUN: begin
                    if (instr_valid && is_serial) begin
                        state_d     = DRAIN;
                        pend_iret_d = (opcode == OP_IRET);
                    end else if (xfer) begin
                        ctrl_d = decode(opcode);
                        vld_d  = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
                        ill_d  = !op_defined;
`endif
                        if (opcode == OP_MUL && MUL_WAIT_CNT != '0) begin
                            cnt_d   = MUL_WAIT_CNT;
                            state_d = MUL_WAIT;
                        end
                    end
                end
                MUL_WAIT: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = RUN;
                end
                DRAIN: begin
                    if (ex_empty) begin
                        ctrl_d.tlb_write = !pend_iret_q;
                        ctrl_d.iret      = pend_iret_q;
                        vld_d            = 1'b1;
                        state_d          = ISSUED;
                    end
                end
                ISSUED:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            ctrl_q      <= '0;
            vld_q       <= 1'b0;
            cnt_q       <= '0;
            pend_iret_q <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ill_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            vld_q       <= vld_d;
            cnt_q       <= cnt_d;
            pend_iret_q <= pend_iret_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ill_q       <= ill_d;
`endif
        end
    end

    assign ctrl_valid = vld_q;
    assign {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src,
            reg_write, jump, word, tlb_write, iret, ignore_op2} = ctrl_q;

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// Bench for decode_ctrl_seq: decode table vectors, hand-written multi-cycle sequences,
// and random traffic checked each cycle against an occupancy-based reference model.
module tb_decode_ctrl_seq;
    localparam int OPC_W   = 6;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 4;

    localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_MUL = 6'h02;
    localparam logic [5:0] OP_LDB = 6'h10, OP_LDW = 6'h11, OP_STB = 6'h12, OP_STW = 6'h13;
    localparam logic [5:0] OP_MOVRM1 = 6'h20, OP_BEQ = 6'h30, OP_JUMP = 6'h31;
    localparam logic [5:0] OP_TLBWR = 6'h3C, OP_IRET = 6'h3D;

    logic clk = 1'b0;
    logic reset, instr_valid, stall_in, flush, ex_empty;
    logic [OPC_W-1:0] opcode;
    logic ready, ctrl_valid, reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src;
    logic reg_write, jump, word, tlb_write, iret, ignore_op2, busy;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_op;
`endif

    decode_ctrl_seq #(.OPC_W(OPC_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .stall_in(stall_in), .flush(flush), .ex_empty(ex_empty), .ready(ready),
        .ctrl_valid(ctrl_valid), .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
        .reg_write(reg_write), .jump(jump), .word(word), .tlb_write(tlb_write),
        .iret(iret), .ignore_op2(ignore_op2), .busy(busy)
`ifdef DECODE_ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: remaining MUL bubbles, one pending serialising op, one gap cycle
    logic [11:0] m_bits;
    logic        m_vld, m_ill, m_pend, m_gap;
    logic [11:0] m_pend_bits;
    int          m_mul_left;

    // bit order: reg_dst branch mem_read mem_to_reg mem_write alu_src reg_write jump word tlb iret ign
    function automatic logic [11:0] ref_decode(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL: return 12'h820;
            OP_LDB:    return 12'h360;
            OP_LDW:    return 12'h368;
            OP_STB:    return 12'h0C0;
            OP_STW:    return 12'h0C8;
            OP_BEQ:    return 12'h400;
            OP_JUMP:   return 12'h010;
            OP_MOVRM1: return 12'h821;
            OP_TLBWR:  return 12'h004;
            OP_IRET:   return 12'h002;
            default:   return 12'h000;
        endcase
    endfunction

    function automatic logic ref_defined(input logic [5:0] op);
        return (ref_decode(op) != 12'h000);
    endfunction

    function automatic logic m_busy();
        return (m_mul_left > 0) || m_pend || m_gap;
    endfunction

    function automatic logic [11:0] dut_word();
        return {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src,
                reg_write, jump, word, tlb_write, iret, ignore_op2};
    endfunction

    task automatic model_clear();
        m_bits = '0; m_vld = 0; m_ill = 0; m_pend = 0; m_gap = 0;
        m_pend_bits = '0; m_mul_left = 0;
    endtask

    task automatic model_step();
        if (reset || flush) begin
            model_clear();
        end else if (!stall_in) begin
            m_vld = 0; m_bits = '0; m_ill = 0;
            if (m_mul_left > 0) begin
                m_mul_left--;
            end else if (m_pend) begin
                if (ex_empty) begin
                    m_vld = 1; m_bits = m_pend_bits; m_pend = 0; m_gap = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else if (instr_valid && (opcode == OP_TLBWR || opcode == OP_IRET)) begin
                m_pend = 1; m_pend_bits = ref_decode(opcode);
            end else if (instr_valid) begin
                m_vld = 1; m_bits = ref_decode(opcode); m_ill = !ref_defined(opcode);
                if (opcode == OP_MUL) m_mul_left = MUL_LAT - 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [5:0] op, input logic st,
                         input logic fl, input logic ee);
        instr_valid = iv; opcode = op; stall_in = st; flush = fl; ex_empty = ee;
    endtask

    task automatic tick();
        #2;
        check("ready", 32'(ready), 32'(!reset && !stall_in && !m_busy()));
        @(posedge clk);
        model_step();
        #1;
        check("ctrl_valid", 32'(ctrl_valid), 32'(m_vld));
        check("ctrl_bits", 32'(dut_word()), 32'(m_bits));
        check("busy", 32'(busy), 32'(m_busy()));
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("illegal_op", 32'(illegal_op), 32'(m_ill));
`endif
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[12];
    logic [5:0] pool[14];

    initial begin
        int v, low;
        tbl[0]  = '{OP_ADD, 12'h820};    tbl[1]  = '{OP_SUB, 12'h820};
        tbl[2]  = '{OP_MUL, 12'h820};    tbl[3]  = '{OP_LDB, 12'h360};
        tbl[4]  = '{OP_LDW, 12'h368};    tbl[5]  = '{OP_STB, 12'h0C0};
        tbl[6]  = '{OP_STW, 12'h0C8};    tbl[7]  = '{OP_BEQ, 12'h400};
        tbl[8]  = '{OP_JUMP, 12'h010};   tbl[9]  = '{OP_MOVRM1, 12'h821};
        tbl[10] = '{6'h3F, 12'h000};     tbl[11] = '{6'h05, 12'h000};
        pool = '{OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_STB, OP_STW,
                 OP_BEQ, OP_JUMP, OP_MOVRM1, OP_TLBWR, OP_IRET, 6'h3F, 6'h07};

        model_clear();
        reset = 1'b1;
        drive(0, OP_ADD, 0, 0, 1);
        #1;
        check("rst_ready", 32'(ready), 0);
        check("rst_valid", 32'(ctrl_valid), 0);
        check("rst_bits", 32'(dut_word()), 0);
        check("rst_busy", 32'(busy), 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // decode table
        for (int i = 0; i < 12; i++) begin
            drive(1, tbl[i].op, 0, 0, 1);
            tick();
            check("tbl_valid", 32'(ctrl_valid), 1);
            check("tbl_bits", 32'(dut_word()), 32'(tbl[i].exp));
            drive(0, OP_ADD, 0, 0, 1);
            repeat (3) tick();
        end

        // back-to-back ADD, LDW, STB
        v = 0;
        drive(1, OP_ADD, 0, 0, 1); tick(); v += int'(ctrl_valid);
        check("b2b_add", 32'(dut_word()), 32'h820);
        drive(1, OP_LDW, 0, 0, 1); tick(); v += int'(ctrl_valid);
        check("b2b_ldw", 32'(dut_word()), 32'h368);
        drive(1, OP_STB, 0, 0, 1); tick(); v += int'(ctrl_valid);
        check("b2b_stb", 32'(dut_word()), 32'h0C0);
        check("b2b_count", 32'(v), 3);
        drive(0, OP_ADD, 0, 0, 1); tick();

        // MUL with ADD held behind it
        drive(1, OP_MUL, 0, 0, 1); tick();
        drive(1, OP_ADD, 0, 0, 1);
        low = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (ready) break;
            low++;
            tick();
        end
        check("mul_ready_low", 32'(low), 2);
        tick();
        check("mul_then_add", 32'({ctrl_valid, dut_word()}), 32'h1820);
        drive(0, OP_ADD, 0, 0, 1); tick();

        // IRET waits for drain
        drive(1, OP_IRET, 0, 0, 0); tick();
        drive(0, OP_ADD, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("drain_busy", 32'(busy), 1);
            check("drain_ready", 32'(ready), 0);
        end
        drive(0, OP_ADD, 0, 0, 1); tick();
        check("iret_issue", 32'({ctrl_valid, iret}), 32'h3);
        tick();
        check("iret_gap", 32'(ctrl_valid), 0);
        tick();
        check("iret_done", 32'(busy), 0);

        // stall for 3 cycles inside MUL_WAIT
        drive(1, OP_MUL, 0, 0, 1); tick();
        drive(0, OP_ADD, 0, 0, 1);
        low = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (ready) break;
            low++;
            stall_in = (k >= 1 && k <= 3);
            tick();
        end
        check("mul_stall_wait", 32'(low), 5);

        // stall holds a valid word
        drive(1, OP_BEQ, 0, 0, 1); tick();
        drive(1, OP_ADD, 1, 0, 1); tick(); tick();
        check("stall_hold", 32'({ctrl_valid, dut_word()}), 32'h1400);
        drive(0, OP_ADD, 0, 0, 1); tick();

        // flush with a transfer, then flush during DRAIN
        drive(1, OP_LDB, 0, 1, 1); tick();
        check("flush_xfer", 32'({ctrl_valid, dut_word(), busy}), 0);
        drive(0, OP_ADD, 0, 0, 1); #1;
        check("flush_ready", 32'(ready), 1);
        drive(1, OP_TLBWR, 0, 0, 0); tick();
        drive(0, OP_ADD, 0, 1, 0); tick();
        check("flush_drain", 32'({ctrl_valid, dut_word(), busy}), 0);
        drive(0, OP_ADD, 0, 0, 0); #1;
        check("flush_drain_rdy", 32'(ready), 1);
        tick();

        // async reset mid-DRAIN and with a valid word registered
        drive(1, OP_IRET, 0, 0, 0); tick();
        drive(0, OP_ADD, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("areset_busy", 32'(busy), 0);
        check("areset_ready", 32'(ready), 0);
        model_clear();
        tick();
        reset = 1'b0;
        drive(1, OP_LDW, 0, 0, 1); tick();
        drive(0, OP_ADD, 0, 0, 1);
        #2 reset = 1'b1;
        #1;
        check("areset_out", 32'({ctrl_valid, dut_word()}), 0);
        model_clear();
        tick();
        reset = 1'b0;
        tick();

`ifdef DECODE_ILLEGAL_TRAP_EN
        drive(1, 6'h3F, 0, 0, 1); tick();
        check("illegal_pulse", 32'({illegal_op, ctrl_valid, dut_word()}), 32'h3000);
        drive(0, OP_ADD, 0, 0, 1); tick();
        check("illegal_clear", 32'(illegal_op), 0);
`endif

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0,
                  pool[$urandom_range(0, 13)],
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
